// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, instruction-memory handshake, branch redirect, decoder code register
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall                      downstream not ready; hold the issued instruction
//   branch_taken/branch_target redirect request and its address
//   imem_req/imem_addr         registered read request to instruction memory
//   imem_ready/imem_data       memory response handshake and 24-bit word
//   code/code_valid/pc         registered instruction to the decoder and its address
module instruction_fetch #(
    parameter int                     ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [23:0]           imem_data,
    output logic [23:0]           code,
    output logic                  code_valid,
    output logic [ADDR_WIDTH-1:0] pc
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ISSUE   = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] fetch_pc_next;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] discard_dest;

    // Wraps modulo 2^ADDR_WIDTH by construction.
    assign pc_inc = pc + ADDR_WIDTH'(1);

    // A redirect arriving on the same edge the stale response lands wins over
    // the one already parked in fetch_pc_next.
    assign discard_dest = branch_taken ? branch_target : fetch_pc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            imem_req      <= 1'b0;
            imem_addr     <= RESET_PC;
            code          <= 24'h000000;
            code_valid    <= 1'b0;
            pc            <= RESET_PC;
            fetch_pc      <= RESET_PC;
            fetch_pc_next <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Branch requests are ignored here.
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= fetch_pc;
                end

                REQ: begin
                    if (imem_ready) begin
                        if (branch_taken) begin
                            // Response belongs to the wrong path: drop it and
                            // reissue at the target straight away.
                            fetch_pc  <= branch_target;
                            imem_addr <= branch_target;
                        end else begin
                            code       <= imem_data;
                            pc         <= fetch_pc;
                            code_valid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= ISSUE;
                        end
                    end else if (branch_taken) begin
                        // Memory still owns the current address; park the
                        // target until the in-flight read completes.
                        fetch_pc_next <= branch_target;
                        state         <= DISCARD;
                    end
                end

                DISCARD: begin
                    if (branch_taken) begin
                        fetch_pc_next <= branch_target;
                    end
                    if (imem_ready) begin
                        fetch_pc  <= discard_dest;
                        imem_addr <= discard_dest;
                        state     <= REQ;
                    end
                end

                ISSUE: begin
                    // Branch takes priority over stall.
                    if (branch_taken) begin
                        fetch_pc   <= branch_target;
                        imem_addr  <= branch_target;
                        imem_req   <= 1'b1;
                        code_valid <= 1'b0;
                        state      <= REQ;
                    end else if (!stall) begin
                        fetch_pc   <= pc_inc;
                        imem_addr  <= pc_inc;
                        imem_req   <= 1'b1;
                        code_valid <= 1'b0;
                        state      <= REQ;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized scoreboard bench for instruction_fetch
module tb_instruction_fetch;

    localparam int         AW  = 8;
    localparam logic [7:0] RPC = 8'h30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready = 1'b0;
    logic [23:0] imem_data;
    logic [23:0] code;
    logic        code_valid;
    logic [7:0]  pc;

    logic [23:0] mem [256];

    int checks = 0;
    int errors = 0;
    bit sb_on  = 1'b0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_data     (imem_data),
        .code          (code),
        .code_valid    (code_valid),
        .pc            (pc)
    );

    typedef struct {
        bit          req;
        logic [7:0]  addr;
        bit          valid;
        logic [7:0]  pc;
        logic [23:0] code;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: a request is outstanding or an instruction is held;
    // an outstanding request may be marked as poisoned by a redirect.
    bit          m_run;
    bit          m_req;
    bit          m_valid;
    bit          m_drop;
    logic [7:0]  m_addr;
    logic [7:0]  m_redir;
    logic [7:0]  m_pc;
    logic [23:0] m_code;
    int          issued;

    task automatic model_reset();
        m_run = 0; m_req = 0; m_valid = 0; m_drop = 0;
        m_addr = RPC; m_redir = 8'h00; m_pc = RPC; m_code = 24'h0;
    endtask

    task automatic model_step(input bit b, input logic [7:0] t, input bit s, input bit r);
        if (!m_run) begin
            m_run = 1;
            m_req = 1;
        end else if (m_valid) begin
            if (b || !s) begin
                m_valid = 0;
                m_req   = 1;
                m_addr  = b ? t : m_pc + 8'd1;
            end
        end else if (m_drop) begin
            if (b) m_redir = t;
            if (r) begin
                m_drop = 0;
                m_addr = m_redir;
            end
        end else if (r) begin
            if (b) begin
                m_addr = t;
            end else begin
                m_req   = 0;
                m_valid = 1;
                m_pc    = m_addr;
                m_code  = mem[m_addr];
                issued++;
            end
        end else if (b) begin
            m_drop  = 1;
            m_redir = t;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_random();
        branch_taken  = ($urandom_range(0, 5) == 0);
        branch_target = 8'($urandom);
        stall         = ($urandom_range(0, 2) == 0);
        imem_ready    = ($urandom_range(0, 1) == 1);
    endtask

    // Monitor: compares the DUT against the expectation pushed for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_on && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_req",   {31'd0, imem_req},   {31'd0, e.req});
                chk("imem_addr",  {24'd0, imem_addr},  {24'd0, e.addr});
                chk("code_valid", {31'd0, code_valid}, {31'd0, e.valid});
                chk("pc",         {24'd0, pc},         {24'd0, e.pc});
                chk("code",       {8'd0, code},        {8'd0, e.code});
            end
        end
    end

    initial begin
        exp_t e;
        for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
        model_reset();
        issued = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst imem_req",   {31'd0, imem_req},   32'd0);
        chk("rst imem_addr",  {24'd0, imem_addr},  {24'd0, RPC});
        chk("rst code_valid", {31'd0, code_valid}, 32'd0);
        chk("rst pc",         {24'd0, pc},         {24'd0, RPC});
        chk("rst code",       {8'd0, code},        32'd0);

        // Randomized run against the model
        sb_on = 1'b1;
        rst_n = 1'b1;
        drive_random();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_step(branch_taken, branch_target, stall, imem_ready);
            e.req = m_req; e.addr = m_addr; e.valid = m_valid; e.pc = m_pc; e.code = m_code;
            exp_q.push_back(e);
            #1;
            drive_random();
        end
        @(negedge clk);
        #1;
        chk("scoreboard drained", exp_q.size(), 32'd0);
        chk("instructions issued", {31'd0, (issued > 200)}, 32'd1);
        sb_on = 1'b0;

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async imem_req",   {31'd0, imem_req},   32'd0);
        chk("async code_valid", {31'd0, code_valid}, 32'd0);
        chk("async pc",         {24'd0, pc},         {24'd0, RPC});

        // Branch ignored in IDLE, redirect with data present, wrap FF -> 00
        @(posedge clk);
        #1;
        rst_n = 1'b1; branch_taken = 1'b1; branch_target = 8'hFF; imem_ready = 1'b1; stall = 1'b0;
        @(posedge clk);
        #1;
        chk("idle ignores branch addr", {24'd0, imem_addr}, {24'd0, RPC});
        chk("first req",                {31'd0, imem_req},  32'd1);
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        chk("redirect addr",        {24'd0, imem_addr},  32'h0FF);
        chk("redirect drops data",  {31'd0, code_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("wrap valid", {31'd0, code_valid}, 32'd1);
        chk("wrap pc",    {24'd0, pc},         32'h0FF);
        chk("wrap code",  {8'd0, code},        {8'd0, mem[255]});
        chk("issue no req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("wrap next addr", {24'd0, imem_addr}, 32'd0);
        chk("wrap next req",  {31'd0, imem_req},  32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-REQ reset imem_req",   {31'd0, imem_req},   32'd0);
        chk("mid-REQ reset code_valid", {31'd0, code_valid}, 32'd0);
        chk("mid-REQ reset code",       {8'd0, code},        32'd0);
        chk("mid-REQ reset addr",       {24'd0, imem_addr},  {24'd0, RPC});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that sits directly upstream of the instruction decoder/control unit. Holds the program counter, issues requests to instruction memory over a request/ready handshake, and captures each 24-bit instruction word into the register that drives the decoder's `code` input. Handles stalls from later stages and branch redirects, including redirects that arrive while a memory read is still in flight.

## Interface
- `ADDR_WIDTH`, default 8: program counter and instruction-memory address width, in words.
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `stall` input 1: downstream is not ready; hold the current instruction.
- `branch_taken` input 1: redirect request, sampled on a clock edge.
- `branch_target` input ADDR_WIDTH: redirect address, valid when `branch_taken`=1.
- `imem_req` output 1: read request to instruction memory.
- `imem_addr` output ADDR_WIDTH: read address; stable while `imem_req`=1.
- `imem_ready` input 1: memory returns `imem_data` this cycle.
- `imem_data` input 24: instruction word from memory.
- `code` output 24: registered instruction word to the decoder.
- `code_valid` output 1: `code` holds a live instruction.
- `pc` output ADDR_WIDTH: address of the instruction currently in `code`.

## Operation
- The FSM has four states:
  - IDLE: entered on reset. Moves to REQ on the next edge.
  - REQ: drives `imem_req`=1 and `imem_addr`=fetch_pc.
  - ISSUE: drives `code_valid`=1.
  - DISCARD: drives `imem_req`=1 and keeps the old address.
- REQ, with `imem_ready`=1 and no branch: `code`<=`imem_data`, `pc`<=fetch_pc, go to ISSUE.
- REQ, with `branch_taken`=1 and `imem_ready`=1 on the same edge: drop the data, fetch_pc<=`branch_target`, stay in REQ.
- REQ, with `branch_taken`=1 and `imem_ready`=0: latch `branch_target` into fetch_pc_next and go to DISCARD. The address must not change mid-transaction.
- DISCARD: wait for `imem_ready`=1, drop the data, fetch_pc<=fetch_pc_next, go to REQ. A further `branch_taken` while in DISCARD overwrites fetch_pc_next; the last redirect wins.
- ISSUE, with `stall`=1: hold `code`, `pc` and `code_valid`. No memory request.
- ISSUE, with `stall`=0 and no branch: fetch_pc<=`pc`+1, go to REQ.
- ISSUE, with `branch_taken`=1: fetch_pc<=`branch_target` and go to REQ, whatever the value of `stall`. Branch has priority over stall.
- PC arithmetic is modulo 2^ADDR_WIDTH. `pc`=all-ones increments to 0 with no error.
- `code` keeps its last value when `code_valid`=0. The decoder's consumers must qualify their actions with `code_valid`.

## Timing
- Reset values:
  - state = IDLE
  - `imem_req` = 0
  - `imem_addr` = `RESET_PC`
  - `code` = 24'h000000
  - `code_valid` = 0
  - `pc` = `RESET_PC`
  - fetch_pc = `RESET_PC`
  - fetch_pc_next = 0
- Reset asserted mid-operation: immediate return to the reset values. An outstanding memory response after reset is ignored because `imem_req`=0 in IDLE.
- Latency, counted after `rst_n` rises:
  - Edge 1: IDLE→REQ.
  - With `imem_ready` already high, `code_valid`=1 after edge 2.
  - Each extra wait cycle adds 1.
- Best-case throughput is 1 instruction per 2 cycles (REQ + ISSUE).
- `imem_req` and `imem_addr` are registered and decoded from state. `imem_addr` changes only on entry to REQ.
- `code_valid` falls on the edge that leaves ISSUE. It rises on the edge that captures data.
- `branch_taken` is ignored in IDLE.

## Test plan
- Reset then free run, with memory `imem_ready`=1 always and `mem[i]`=i: `code` shows 0,1,2,3 on `code_valid` cycles 2 apart, with `pc` matching. The first valid cycle is at edge 2 after reset release.
- Memory wait: `imem_ready` low for 3 cycles at address 5. `imem_addr`=5 is held for all 4 REQ cycles. `code`=`mem[5]` follows 1 cycle after ready.
- Stall: `stall`=1 for 4 cycles while `code`=`mem[2]`. `code`, `pc`=2 and `code_valid`=1 hold, with `imem_req`=0 throughout. The next fetch address is 3.
- Redirect in flight: `branch_taken`=1 with target 8A while in REQ at address 4 and `imem_ready`=0. Expected sequence:
  - DISCARD, with address 4 held.
  - The response for address 4 is dropped, and `code_valid` stays 0.
  - The next request is at 8A, then `code`=`mem[8A]` with `pc`=8A.
- Branch plus stall in ISSUE: target 10 and `stall`=1 on the same edge. `code_valid` drops next cycle, and the next request is at 10.
- Wrap and async reset: run from `pc`=FF, and the next fetch is 00. Pulse `rst_n` low mid-REQ: `imem_req`=0 and `code_valid`=0 immediately, with no clock edge needed.
